// File: rtl/cube_pkg.sv
// Shared sizes, scan-state encoding and voxel addressing for the LED cube driver.
package cube_pkg;

    localparam int CUBE_N  = 8;
    localparam int COORD_W = 4;
    localparam int ROW_W   = 64;

    typedef enum logic [1:0] {
        SHIFT,
        LATCH,
        HOLD
    } scan_state_t;

    // Bit position of voxel (x,z) inside one Y-layer row: z*8+x.
    function automatic logic [5:0] voxel_idx(input logic [2:0] x, input logic [2:0] z);
        return {z, x};
    endfunction

endpackage

// File: rtl/sr_serializer.sv
// Shifts a 64-bit row into the 74HC595 chain MSB first; sr_clk low then high for SR_DIV cycles per bit.
module sr_serializer
    import cube_pkg::*;
#(
    parameter int SR_DIV = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [ROW_W-1:0] word,
    output logic             sr_data,
    output logic             sr_clk,
    output logic             done
);

    localparam int DIV_W = (SR_DIV > 1) ? $clog2(SR_DIV) : 1;

    logic [DIV_W-1:0] div_cnt;
    logic [5:0]       bit_cnt;
    logic [ROW_W-1:0] shreg;
    logic             busy;
    logic             div_last;

    assign div_last = (div_cnt == DIV_W'(SR_DIV - 1));
    // Asserted during the final high phase so the caller can move on without a gap cycle.
    assign done     = busy && sr_clk && div_last && (bit_cnt == 6'd63);

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            sr_data <= 1'b0;
            sr_clk  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b0;
        end else if (load) begin
            shreg   <= word;
            sr_data <= word[ROW_W-1];
            sr_clk  <= 1'b0;
            div_cnt <= '0;
            bit_cnt <= '0;
            busy    <= 1'b1;
        end else if (busy) begin
            if (div_last) begin
                div_cnt <= '0;
                if (!sr_clk) begin
                    sr_clk <= 1'b1;
                end else begin
                    sr_clk <= 1'b0;
                    if (bit_cnt == 6'd63) begin
                        busy    <= 1'b0;
                        sr_data <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + 6'd1;
                        shreg   <= {shreg[ROW_W-2:0], 1'b0};
                        sr_data <= shreg[ROW_W-2];
                    end
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/led_cube_scan_driver.sv
// Double-buffered 8x8x8 voxel image with a layer-multiplexed scan into a 74HC595 column chain.
module led_cube_scan_driver
    import cube_pkg::*;
#(
    parameter int SR_DIV     = 4,
    parameter int LAYER_HOLD = 50000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [COORD_W-1:0] iX,
    input  logic [COORD_W-1:0] iY,
    input  logic [COORD_W-1:0] iZ,
    input  logic               clear,
    input  logic               swap_req,
    output logic               swap_ack,
    output logic               frame_start,
    output logic               coord_err,
    output logic               sr_data,
    output logic               sr_clk,
    output logic               sr_latch,
    output logic [CUBE_N-1:0]  layer_sel
);

    localparam int LATCH_W = (SR_DIV > 1) ? $clog2(SR_DIV) : 1;
    localparam int HOLD_W  = (LAYER_HOLD > 1) ? $clog2(LAYER_HOLD) : 1;

    logic [CUBE_N-1:0][ROW_W-1:0] buf_a;
    logic [CUBE_N-1:0][ROW_W-1:0] buf_b;
    logic                         front_sel;
    logic                         pending;
    scan_state_t                  state;
    logic                         start;
    logic [2:0]                   layer;
    logic [LATCH_W-1:0]           latch_cnt;
    logic [HOLD_W-1:0]            hold_cnt;

    logic             wr;
    logic             hold_last;
    logic             swap_now;
    logic             front_next;
    logic             load;
    logic             ser_done;
    logic [2:0]       layer_next;
    logic [5:0]       idx;
    logic [ROW_W-1:0] row_word;

    always_comb begin
        wr         = enable && !(iX[3] || iY[3] || iZ[3]);
        idx        = voxel_idx(iX[2:0], iZ[2:0]);
        hold_last  = (state == HOLD) && (hold_cnt == HOLD_W'(LAYER_HOLD - 1));
        swap_now   = hold_last && (layer == 3'd7) && (pending || swap_req);
        front_next = front_sel ^ swap_now;
        load       = ((state == SHIFT) && start) || hold_last;
        layer_next = hold_last ? layer + 3'd1 : layer;
        // Row is taken from the post-swap front so a new frame starts on the new image.
        row_word   = front_next ? buf_b[layer_next] : buf_a[layer_next];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_a <= '0;
            buf_b <= '0;
        end else if (front_next) begin
            if (swap_now || clear) buf_a <= '0;
            if (wr) buf_a[iY[2:0]][idx] <= 1'b1;
        end else begin
            if (swap_now || clear) buf_b <= '0;
            if (wr) buf_b[iY[2:0]][idx] <= 1'b1;
        end
    end

    sr_serializer #(.SR_DIV(SR_DIV)) u_ser (
        .clk    (clk),
        .reset  (reset),
        .load   (load),
        .word   (row_word),
        .sr_data(sr_data),
        .sr_clk (sr_clk),
        .done   (ser_done)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SHIFT;
            start       <= 1'b1;
            layer       <= '0;
            latch_cnt   <= '0;
            hold_cnt    <= '0;
            front_sel   <= 1'b0;
            pending     <= 1'b0;
            swap_ack    <= 1'b0;
            frame_start <= 1'b0;
            coord_err   <= 1'b0;
            sr_latch    <= 1'b0;
            layer_sel   <= '0;
        end else begin
            frame_start <= 1'b0;
            swap_ack    <= swap_now;
            coord_err   <= enable && (iX[3] || iY[3] || iZ[3]);
            front_sel   <= front_next;
            if (swap_now)      pending <= 1'b0;
            else if (swap_req) pending <= 1'b1;

            case (state)
                SHIFT: begin
                    if (start) begin
                        start       <= 1'b0;
                        frame_start <= (layer == 3'd0);
                    end else if (ser_done) begin
                        state     <= LATCH;
                        sr_latch  <= 1'b1;
                        latch_cnt <= '0;
                    end
                end
                LATCH: begin
                    if (latch_cnt == LATCH_W'(SR_DIV - 1)) begin
                        state            <= HOLD;
                        sr_latch         <= 1'b0;
                        layer_sel        <= '0;
                        layer_sel[layer] <= 1'b1;
                        hold_cnt         <= '0;
                    end else begin
                        latch_cnt <= latch_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    if (hold_last) begin
                        state       <= SHIFT;
                        layer_sel   <= '0;
                        layer       <= layer_next;
                        frame_start <= (layer == 3'd7);
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end
                default: state <= SHIFT;
            endcase
        end
    end

endmodule

// File: tb/tb_led_cube_scan_driver.sv
// Scoreboard bench: stimulus queues the expected row for every displayed layer, the monitor checks each.
module tb_led_cube_scan_driver;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [3:0] iX, iY, iZ;
    logic       clear;
    logic       swap_req;
    logic       swap_ack;
    logic       frame_start;
    logic       coord_err;
    logic       sr_data;
    logic       sr_clk;
    logic       sr_latch;
    logic [7:0] layer_sel;

    led_cube_scan_driver #(.SR_DIV(1), .LAYER_HOLD(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .enable     (enable),
        .iX         (iX),
        .iY         (iY),
        .iZ         (iZ),
        .clear      (clear),
        .swap_req   (swap_req),
        .swap_ack   (swap_ack),
        .frame_start(frame_start),
        .coord_err  (coord_err),
        .sr_data    (sr_data),
        .sr_clk     (sr_clk),
        .sr_latch   (sr_latch),
        .layer_sel  (layer_sel)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [7:0]  sel;
        logic [63:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [63:0] img[8];
    int          checks = 0;
    int          errors = 0;
    int          ack_count = 0;
    int          cerr_count = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic push_img();
        exp_t e;
        for (int l = 0; l < 8; l++) begin
            e.sel    = '0;
            e.sel[l] = 1'b1;
            e.word   = img[l];
            exp_q.push_back(e);
        end
    endtask

    task automatic clear_img();
        for (int l = 0; l < 8; l++) img[l] = '0;
    endtask

    task automatic wr(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z);
        enable = 1'b1; iX = x; iY = y; iZ = z;
        @(negedge clk);
        enable = 1'b0;
    endtask

    task automatic pulse_swap();
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
    endtask

    task automatic wait_fs(output logic ack);
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (frame_start) break;
        end
        chk("frame_start_seen", 64'(frame_start), 64'd1);
        ack = swap_ack;
    endtask

    task automatic wait_sel(input logic [7:0] want);
        for (int n = 0; n < 1500; n++) begin
            @(negedge clk);
            if (layer_sel == want) break;
        end
        chk("layer_sel_reached", 64'(layer_sel), 64'(want));
    endtask

    // Monitor state
    logic        prev_srclk = 1'b0;
    logic        prev_latch = 1'b0;
    logic [7:0]  prev_sel = '0;
    logic [63:0] acc = '0;
    logic [63:0] latched = '0;
    int          nbits = 0;
    int          latched_n = 0;
    int          hold_len = 0;
    int          latch_len = 0;
    exp_t        got;

    always @(negedge clk) begin
        if (swap_ack) ack_count++;
        if (coord_err) cerr_count++;
        if (reset) begin
            nbits = 0; hold_len = 0; latch_len = 0;
            prev_srclk = 1'b0; prev_latch = 1'b0; prev_sel = '0;
        end else begin
            if (sr_clk && !prev_srclk) begin
                acc = {acc[62:0], sr_data};
                nbits++;
            end
            if (sr_latch) begin
                latch_len++;
                if (!prev_latch) begin
                    latched   = acc;
                    latched_n = nbits;
                    nbits     = 0;
                    chk("latch_sr_clk_low", 64'(sr_clk), 64'd0);
                    chk("latch_blanked", 64'(layer_sel), 64'd0);
                end
            end else if (prev_latch) begin
                chk("latch_len", 64'(latch_len), 64'd1);
                latch_len = 0;
            end
            if (layer_sel != 8'h00) begin
                hold_len++;
                if (prev_sel == 8'h00) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL exp_underflow actual=%0h required=none", layer_sel);
                    end else begin
                        got = exp_q.pop_front();
                        chk("layer_sel", 64'(layer_sel), 64'(got.sel));
                        chk("row_word", latched, got.word);
                        chk("bits_shifted", 64'(latched_n), 64'd64);
                    end
                end
            end else if (prev_sel != 8'h00) begin
                chk("hold_len", 64'(hold_len), 64'd4);
                hold_len = 0;
            end
            prev_srclk = sr_clk;
            prev_latch = sr_latch;
            prev_sel   = layer_sel;
        end
    end

    initial begin
        logic ack;
        int   n;
        reset = 1'b1; enable = 1'b0; clear = 1'b0; swap_req = 1'b0;
        iX = '0; iY = '0; iZ = '0;
        repeat (3) @(negedge clk);
        chk("reset_outputs", 64'({swap_ack, frame_start, coord_err, sr_data, sr_clk, sr_latch, layer_sel}), 64'd0);

        // Frame 0: empty cube, exact scan timing
        reset = 1'b0;
        @(negedge clk);
        chk("fs_after_reset", 64'(frame_start), 64'd1);
        chk("no_ack_after_reset", 64'(swap_ack), 64'd0);
        clear_img();
        push_img();
        n = 0;
        while (layer_sel == 8'h00 && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("first_hold_delay", 64'(n), 64'd129);
        wr(4'd2, 4'd7, 4'd6);
        pulse_swap();
        wait_fs(ack);
        chk("swap_ack_f1", 64'(ack), 64'd1);

        // Frame 1: voxel (2,7,6) visible; out-of-range write dropped
        clear_img();
        img[7] = 64'h1 << 50;
        push_img();
        enable = 1'b1; iX = 4'd9; iY = 4'd1; iZ = 4'd1;
        @(negedge clk);
        enable = 1'b0;
        chk("coord_err_pulse", 64'(coord_err), 64'd1);
        @(negedge clk);
        chk("coord_err_once", 64'(coord_err), 64'd0);
        pulse_swap();
        wait_fs(ack);
        chk("swap_ack_f2", 64'(ack), 64'd1);

        // Frame 2: empty; two requests give one swap
        clear_img();
        push_img();
        wr(4'd5, 4'd3, 4'd1);
        pulse_swap();
        repeat (50) @(negedge clk);
        pulse_swap();
        wait_fs(ack);
        chk("swap_ack_f3", 64'(ack), 64'd1);

        // Frame 3: voxel (5,3,1); no request so next boundary does not swap
        clear_img();
        img[3] = 64'h1 << 13;
        push_img();
        wait_fs(ack);
        chk("no_swap_without_req", 64'(ack), 64'd0);

        // Frame 4: same image; clear with simultaneous write
        push_img();
        wr(4'd7, 4'd7, 4'd7);
        clear = 1'b1; enable = 1'b1; iX = 4'd0; iY = 4'd0; iZ = 4'd0;
        @(negedge clk);
        clear = 1'b0; enable = 1'b0;
        pulse_swap();
        wait_fs(ack);
        chk("swap_ack_f5", 64'(ack), 64'd1);

        // Frame 5: only (0,0,0); request placed on the boundary cycle itself
        clear_img();
        img[0] = 64'h1;
        push_img();
        wr(4'd1, 4'd4, 4'd2);
        wait_sel(8'h80);
        repeat (3) @(negedge clk);
        swap_req = 1'b1;
        @(negedge clk);
        swap_req = 1'b0;
        chk("fs_f6", 64'(frame_start), 64'd1);
        chk("boundary_req_ack", 64'(swap_ack), 64'd1);

        // Frame 6: voxel (1,4,2); reset in layer 3 shift
        clear_img();
        img[4] = 64'h1 << 17;
        push_img();
        wait_sel(8'h04);
        wait_sel(8'h00);
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("reset_mid_scan", 64'({swap_ack, frame_start, coord_err, sr_data, sr_clk, sr_latch, layer_sel}), 64'd0);
        exp_q.delete();
        reset = 1'b0;
        @(negedge clk);
        chk("fs_after_mid_reset", 64'(frame_start), 64'd1);
        clear_img();
        push_img();
        pulse_swap();
        wait_fs(ack);
        chk("swap_ack_after_reset", 64'(ack), 64'd1);
        push_img();

        for (int k = 0; k < 1500; k++) begin
            if (exp_q.size() == 0) break;
            @(negedge clk);
        end
        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        chk("total_swap_acks", 64'(ack_count), 64'd6);
        chk("total_coord_errs", 64'(cerr_count), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
